// File: rtl/mmio_display_port.sv
// Memory-mapped front-panel peripheral: multiplexed seven-segment display driven
// from a per-frame snapshot, plus debounced buttons with clear-on-read press flags.
module mmio_display_port #(
    parameter int unsigned       ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 12'd96,
    parameter int unsigned       DIGITS      = 4,
    parameter int unsigned       BTNS        = 2,
    parameter int unsigned       REFRESH_DIV = 50000,
    parameter int unsigned       DEBOUNCE    = 1000
) (
    input  logic              clk,
    input  logic              res,
    input  logic              sel,
    input  logic              ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       data_in,
    output logic [15:0]       data_out,
    output logic              hit,
    input  logic [BTNS-1:0]   btn_n,
    output logic [DIGITS-1:0] dig,
    output logic [7:0]        seg
);

    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam int unsigned DW = $clog2(DEBOUNCE + 1);
    localparam logic [31:0] NIB_MASK =
        (DIGITS >= 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * DIGITS)) - 32'd1);
    localparam logic [15:0] CTRL_MASK = 16'hFF03;

    function automatic logic [6:0] hex7seg(input logic [3:0] n);
        hex7seg = 7'h00;
        case (n)
            4'h0: hex7seg = 7'h3F;
            4'h1: hex7seg = 7'h06;
            4'h2: hex7seg = 7'h5B;
            4'h3: hex7seg = 7'h4F;
            4'h4: hex7seg = 7'h66;
            4'h5: hex7seg = 7'h6D;
            4'h6: hex7seg = 7'h7D;
            4'h7: hex7seg = 7'h07;
            4'h8: hex7seg = 7'h7F;
            4'h9: hex7seg = 7'h6F;
            4'hA: hex7seg = 7'h77;
            4'hB: hex7seg = 7'h7C;
            4'hC: hex7seg = 7'h39;
            4'hD: hex7seg = 7'h5E;
            4'hE: hex7seg = 7'h79;
            4'hF: hex7seg = 7'h71;
            default: hex7seg = 7'h00;
        endcase
    endfunction

    // ---------------- bus decode ----------------
    logic [ADDR_W-1:0] offset;
    logic [2:0]        reg_sel;
    logic              wr, rd, rd_edge;

    // Modular subtraction makes addresses below BASE_ADDR wrap high and miss.
    assign offset  = addr - BASE_ADDR;
    assign hit     = (offset < ADDR_W'(5));
    assign reg_sel = offset[2:0];
    assign wr      = sel && !ld && hit;
    assign rd      = sel && ld && hit;
    assign rd_edge = rd && (reg_sel == 3'd4);

    logic [15:0] disp_lo, disp_hi, ctrl_q;

    // NOTE: state is only ever assigned with <= in always_ff so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (res) begin
            disp_lo <= '0;
            disp_hi <= '0;
            ctrl_q  <= 16'h0001;
        end else if (wr) begin
            case (reg_sel)
                3'd0:    disp_lo <= data_in;
                3'd1:    disp_hi <= data_in;
                3'd2:    ctrl_q  <= data_in & CTRL_MASK;
                default: ;
            endcase
        end
    end

    // ---------------- buttons ----------------
    logic [BTNS-1:0] sync1, sync2, lvl, flags, flip;
    logic [DW-1:0]   deb_cnt [BTNS];

    always_comb begin
        for (int k = 0; k < BTNS; k++) begin
            flip[k] = (sync2[k] != lvl[k]) && (deb_cnt[k] == DW'(DEBOUNCE - 1));
        end
    end

    // Inversion happens at the first flop so a cleared synchroniser means "released".
    always_ff @(posedge clk) begin
        if (res) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '0;
            flags <= '0;
            // NOTE: the counter array is reset element by element; it is real state, not RAM.
            for (int k = 0; k < BTNS; k++) deb_cnt[k] <= '0;
        end else begin
            sync1 <= ~btn_n;
            sync2 <= sync1;
            lvl   <= lvl ^ flip;
            flags <= (rd_edge ? '0 : flags) | (flip & ~lvl);
            for (int k = 0; k < BTNS; k++) begin
                if (sync2[k] == lvl[k] || flip[k]) deb_cnt[k] <= '0;
                else                               deb_cnt[k] <= deb_cnt[k] + DW'(1);
            end
        end
    end

    // ---------------- read path ----------------
    logic [15:0] rd_data;

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            3'd0:    rd_data = disp_lo;
            3'd1:    rd_data = disp_hi;
            3'd2:    rd_data = ctrl_q;
            3'd3:    rd_data = 16'(lvl);
            3'd4:    rd_data = 16'(flags);
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) data_out <= '0;
        else     data_out <= rd ? rd_data : '0;
    end

    // ---------------- display ----------------
    logic [RW-1:0] ref_cnt;
    logic [2:0]    idx;
    logic          tick, frame_start;
    logic [31:0]   snap_word, src_word, lz_word;
    logic [7:0]    snap_dp, src_dp;
    logic          snap_en, snap_lzb, src_en, src_lzb;

    // idx is the digit lit by the coming tick; the tick lighting digit 0 starts a frame.
    assign tick        = (ref_cnt == RW'(REFRESH_DIV - 1));
    assign frame_start = tick && (idx == 3'd0);

    logic [3:0]        cur_nib;
    logic              blank;
    logic [DIGITS-1:0] dig_nxt;
    logic [7:0]        seg_nxt;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        src_word = snap_word;
        src_dp   = snap_dp;
        src_en   = snap_en;
        src_lzb  = snap_lzb;
        // The frame-start digit is built from the values being captured on that same tick.
        if (frame_start) begin
            src_word = {disp_hi, disp_lo};
            src_dp   = ctrl_q[15:8];
            src_en   = ctrl_q[0];
            src_lzb  = ctrl_q[1];
        end
        cur_nib = src_word[{idx, 2'b00} +: 4];
        lz_word = (src_word & NIB_MASK) >> {idx, 2'b00};
        blank   = src_lzb && (idx != 3'd0) && (lz_word == 32'd0);
        dig_nxt = '1;
        seg_nxt = 8'hFF;
        if (src_en) begin
            dig_nxt = ~(DIGITS'(1) << idx);
            if (!blank) seg_nxt = {~src_dp[idx], ~hex7seg(cur_nib)};
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            ref_cnt   <= '0;
            idx       <= '0;
            snap_word <= '0;
            snap_dp   <= '0;
            snap_en   <= 1'b1;
            snap_lzb  <= 1'b0;
            dig       <= '1;
            seg       <= 8'hFF;
        end else begin
            ref_cnt <= tick ? '0 : ref_cnt + RW'(1);
            if (tick) begin
                idx <= (idx == 3'(DIGITS - 1)) ? 3'd0 : idx + 3'd1;
                dig <= dig_nxt;
                seg <= seg_nxt;
                if (frame_start) begin
                    snap_word <= src_word;
                    snap_dp   <= src_dp;
                    snap_en   <= src_en;
                    snap_lzb  <= src_lzb;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_display_port.sv
// Directed bench for mmio_display_port: table-driven display frames plus
// hand-written bus, button-debounce and reset sequences.
module tb_mmio_display_port;

    localparam logic [11:0] BASE = 12'd96;

    logic        clk = 1'b0;
    logic        res, sel, ld, hit;
    logic [11:0] addr;
    logic [15:0] data_in, data_out;
    logic [1:0]  btn_n;
    logic [3:0]  dig;
    logic [7:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mmio_display_port #(
        .ADDR_W(12), .BASE_ADDR(12'd96), .DIGITS(4), .BTNS(2),
        .REFRESH_DIV(4), .DEBOUNCE(8)
    ) dut (
        .clk(clk), .res(res), .sel(sel), .ld(ld), .addr(addr),
        .data_in(data_in), .data_out(data_out), .hit(hit),
        .btn_n(btn_n), .dig(dig), .seg(seg)
    );

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic [15:0] ctrl;
        logic [31:0] segs;   // byte k = expected seg for digit k
    } disp_vec_t;

    disp_vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [15:0] d);
        sel = 1'b1; ld = 1'b0; addr = a; data_in = d;
        @(posedge clk); #1;
        sel = 1'b0; data_in = '0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [15:0] d);
        sel = 1'b1; ld = 1'b1; addr = a;
        @(posedge clk); #1;
        d = data_out;
        sel = 1'b0; ld = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [11:0] a, input logic [15:0] exp);
        logic [15:0] d;
        bus_read(a, d);
        check(name, {16'h0, d}, {16'h0, exp});
    endtask

    task automatic wait_frame_start(output bit ok);
        logic [3:0] prev;
        prev = dig;
        ok   = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            if (dig == 4'b1110 && prev != 4'b1110) begin
                ok = 1'b1;
                break;
            end
            prev = dig;
        end
    endtask

    initial begin
        bit          ok1, ok2;
        logic [3:0]  dig_exp;
        logic [15:0] d;

        tbl[0] = '{16'h1234, 16'h0000, 16'h0001, 32'hF9A4B099};
        tbl[1] = '{16'h0005, 16'h0000, 16'h0003, 32'hFFFFFF92};
        tbl[2] = '{16'h0005, 16'h0000, 16'h0001, 32'hC0C0C092};
        tbl[3] = '{16'h0005, 16'h0000, 16'h0501, 32'hC040C012};
        tbl[4] = '{16'h0A0F, 16'h0000, 16'hFF03, 32'hFF08400E};
        tbl[5] = '{16'h0000, 16'hFFFF, 16'h0003, 32'hFFFFFFC0};

        res = 1'b1; sel = 1'b0; ld = 1'b0; addr = '0; data_in = '0; btn_n = 2'b11;
        repeat (3) @(posedge clk);
        #1 res = 1'b0;

        // Reset state
        check("reset dig", {28'h0, dig}, 32'hF);
        check("reset seg", {24'h0, seg}, 32'hFF);
        check("reset data_out", {16'h0, data_out}, 32'h0);
        read_check("reset CTRL", BASE + 12'd2, 16'h0001);
        read_check("reset DISP_LO", BASE, 16'h0000);
        read_check("reset BTN_LVL", BASE + 12'd3, 16'h0000);
        read_check("reset BTN_EDGE", BASE + 12'd4, 16'h0000);

        // Display frames from the vector table
        for (int i = 0; i < 6; i++) begin
            bus_write(BASE, tbl[i].lo);
            bus_write(BASE + 12'd1, tbl[i].hi);
            bus_write(BASE + 12'd2, tbl[i].ctrl);
            wait_frame_start(ok1);
            wait_frame_start(ok2);
            check($sformatf("v%0d frame start seen", i), {31'h0, ok1 & ok2}, 32'h1);
            for (int k = 0; k < 4; k++) begin
                if (k > 0) begin
                    repeat (4) @(posedge clk);
                    #1;
                end
                dig_exp = ~(4'b0001 << k);
                check($sformatf("v%0d d%0d dig", i, k), {28'h0, dig}, {28'h0, dig_exp});
                check($sformatf("v%0d d%0d seg", i, k), {24'h0, seg}, {24'h0, tbl[i].segs[8*k +: 8]});
            end
        end

        // Display disabled: dark from the next frame on
        bus_write(BASE + 12'd2, 16'h0000);
        repeat (40) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("disabled dig %0d", k), {28'h0, dig}, 32'hF);
            check($sformatf("disabled seg %0d", k), {24'h0, seg}, 32'hFF);
            repeat (4) @(posedge clk);
            #1;
        end
        bus_write(BASE + 12'd2, 16'h0001);

        // Address window boundaries
        sel = 1'b1; ld = 1'b1; addr = BASE + 12'd5; #1;
        check("hit base+5", {31'h0, hit}, 32'h0);
        @(posedge clk); #1;
        check("data_out base+5", {16'h0, data_out}, 32'h0);
        addr = BASE - 12'd1; #1;
        check("hit base-1", {31'h0, hit}, 32'h0);
        @(posedge clk); #1;
        check("data_out base-1", {16'h0, data_out}, 32'h0);
        addr = BASE + 12'd4; #1;
        check("hit base+4", {31'h0, hit}, 32'h1);
        addr = BASE; #1;
        check("hit base", {31'h0, hit}, 32'h1);
        sel = 1'b0; ld = 1'b0;
        @(posedge clk); #1;

        bus_write(BASE + 12'd5, 16'h1234);
        bus_write(BASE - 12'd1, 16'h5678);
        bus_write(BASE + 12'd3, 16'hFFFF);
        bus_write(BASE + 12'd2, 16'hFFFF);
        read_check("miss keeps DISP_LO", BASE, 16'h0000);
        read_check("miss keeps DISP_HI", BASE + 12'd1, 16'hFFFF);
        read_check("CTRL reserved bits", BASE + 12'd2, 16'hFF03);
        read_check("BTN_LVL write ignored", BASE + 12'd3, 16'h0000);
        bus_write(BASE + 12'd2, 16'h0001);
        bus_write(BASE, 16'hBEEF);
        read_check("DISP_LO readback", BASE, 16'hBEEF);
        @(posedge clk); #1;
        check("idle data_out", {16'h0, data_out}, 32'h0);

        // Button 0: a short glitch is rejected
        btn_n[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 btn_n[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        read_check("glitch BTN_LVL", BASE + 12'd3, 16'h0000);
        read_check("glitch BTN_EDGE", BASE + 12'd4, 16'h0000);

        // Button 0: a steady press is accepted, edge flag clears on read
        btn_n[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        read_check("press BTN_LVL", BASE + 12'd3, 16'h0001);
        read_check("press BTN_EDGE", BASE + 12'd4, 16'h0001);
        read_check("BTN_EDGE cleared", BASE + 12'd4, 16'h0000);
        btn_n[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        read_check("release BTN_LVL", BASE + 12'd3, 16'h0000);
        read_check("release no edge", BASE + 12'd4, 16'h0000);

        // Button 1: exact latency and an edge landing on a BTN_EDGE read
        btn_n[1] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        read_check("btn1 not yet", BASE + 12'd3, 16'h0000);
        read_check("edge during read", BASE + 12'd4, 16'h0000);
        read_check("edge survives read", BASE + 12'd4, 16'h0002);
        read_check("btn1 BTN_LVL", BASE + 12'd3, 16'h0002);

        // Reset mid-frame with button 1 still held and a read in flight
        wait_frame_start(ok1);
        check("pre-reset frame seen", {31'h0, ok1}, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        sel = 1'b1; ld = 1'b1; addr = BASE; res = 1'b1;
        @(posedge clk); #1;
        check("midreset dig", {28'h0, dig}, 32'hF);
        check("midreset seg", {24'h0, seg}, 32'hFF);
        check("midreset data_out", {16'h0, data_out}, 32'h0);
        res = 1'b0; sel = 1'b0; ld = 1'b0;
        read_check("post-reset CTRL", BASE + 12'd2, 16'h0001);
        read_check("post-reset DISP_LO", BASE, 16'h0000);
        read_check("post-reset BTN_LVL", BASE + 12'd3, 16'h0000);
        bus_read(BASE + 12'd4, d);
        check("post-reset BTN_EDGE", {16'h0, d}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
